demux_lane_monitor: RTL and testbench
=====================================

# demux_lane_monitor

Downstream consumer of the 1-to-8 demux: it watches the eight demux outputs `o0..o7` and counts rising edges per lane. It also flags activity on any lane other than the one currently selected, and lets a host read each lane's count with a read-and-clear handshake. It sits in the same clock domain as the select counter that drives the demux `sel`. The lane inputs are treated as asynchronous and are synchronized internally.

## Interface
Parameters:
- `CNT_W`, default 8: width of each per-lane edge counter; counters saturate at 2^CNT_W-1.
- `SYNC_STAGES`, default 2: flip-flop depth of each lane input synchronizer (minimum 2).

Ports:
- `clk`  in  1  clock, rising-edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `lane_in`  in  8  demux outputs; bit n = `o<n>`; asynchronous to clk.
- `sel`  in  3  lane currently selected at the demux; synchronous to clk.
- `rd_req`  in  1  single-cycle read request; accepted only when `rd_busy`=0.
- `rd_lane`  in  3  lane to read; sampled with `rd_req`.
- `rd_ack`  in  1  host acknowledge; ends a read.
- `rd_valid`  out  1  `rd_data` valid; held until `rd_ack`.
- `rd_data`  out  CNT_W  captured count of `rd_lane`.
- `rd_busy`  out  1  read FSM not IDLE.
- `err_flags`  out  8  sticky bit per lane; set on a rising edge while the lane is not selected.
- `clr_err`  in  1  clears all `err_flags`.

## Operation
- Synchronizer: each `lane_in[n]` passes through `SYNC_STAGES` flops, then one history flop. `rise[n]` = sync output 1 AND history 0.
- Counters: `cnt[n]` increments on `rise[n]`. It saturates at all-ones and never wraps.
- Select tracking: `sel_q` is `sel` registered. A guard counter loads `SYNC_STAGES+1` whenever `sel` != `sel_q`, then decrements to 0.
- Error detect: when the guard is 0 and `rise[n]` occurs with n != `sel_q`, `err_flags[n]` is set.
- Counting continues regardless of error or guard state.
- `clr_err` clears all flags. If a set and `clr_err` occur in the same cycle, the set wins for that bit.
- Read FSM has two states:
  - IDLE: on `rd_req`=1, the FSM captures `cnt[rd_lane]` into `rd_data` and clears that counter in the same cycle, then moves to HOLD.
  - HOLD: `rd_valid`=1 and `rd_data` is stable. On `rd_ack`=1 the FSM returns to IDLE and `rd_valid` drops the next cycle.
- `rd_req` seen while in HOLD is ignored and not queued.
- `rd_ack` seen in IDLE is ignored.
- Clear/increment collision: if `rise[rd_lane]` occurs in the capture cycle, the captured value excludes that edge and the counter becomes 1. No edge is lost.
- Saturated counter read: `rd_data` is all-ones, and the counter restarts from 0 (or 1 on a collision).

## Timing
- Reset values: all counters 0, sync and history flops 0, `sel_q`=0, guard=0, FSM=IDLE, `rd_valid`=0, `rd_data`=0, `rd_busy`=0, `err_flags`=0.
- Reset is asynchronous assert; release is synchronous to the next `clk` edge.
- Reset mid-read: the FSM goes to IDLE and `rd_valid` drops immediately. The pending read is discarded.
- Input latency: a `lane_in` rise that meets setup before edge k is visible in `cnt` after edge k+SYNC_STAGES.
- Read latency: with `rd_req` at edge k, `rd_valid`=1 and `rd_data` are valid after edge k. `rd_busy`=1 from the same point.
- Read throughput: the earliest next accepted `rd_req` is the cycle after `rd_ack` is sampled, i.e. 2 cycles between reads when `rd_ack` is immediate.
- Guard window: error checking is suppressed for SYNC_STAGES+1 cycles after any `sel` change. This absorbs synchronizer lag on the previously selected lane.
- Inputs with a pulse width below 2 clk periods are not guaranteed to be counted.

## Test plan
- Reset check: assert `reset` for 10 ns at t=1 ns → every output reads 0, the FSM is IDLE, and all counters read 0 afterward.
- Basic count: `sel`=3, drive 5 clean pulses on `lane_in[3]`, each 4 cycles high and 4 cycles low, then read lane 3 → `rd_data`=5 one cycle after `rd_req`; a second read of lane 3 → 0; `err_flags`=8'h00.
- Saturation with `CNT_W`=4: drive 20 pulses on lane 0 → read returns 15; an immediate re-read returns 0.
- Error and guard: change `sel` from 2 to 5 while lane 2 is still toggling, with the last lane-2 edge within 2 cycles of the change → `err_flags[2]` stays 0. A lane-6 rise with `sel`=5 and the guard expired → `err_flags`=8'h40. Assert `clr_err` → 8'h00. A set and a clear in the same cycle → the bit stays 1.
- Collision: a lane-1 counter at 7, with `rd_req` for lane 1 issued in the exact cycle `rise[1]` fires → `rd_data`=7, and a later read returns 1.
- Handshake: `rd_req` while in HOLD → no effect and `rd_data` unchanged. Assert reset during HOLD → `rd_valid` is 0 before the next clk edge. `rd_ack` while in IDLE → no state change.

Source files
------------

// File: rtl/demux_lane_monitor_if.sv
// Bus bundle between the lane monitor and its host: lane inputs, select,
// read-and-clear handshake and sticky error flags.
interface demux_lane_monitor_if #(
    parameter int CNT_W = 8
);
    logic [7:0]       lane_in;
    logic [2:0]       sel;
    logic             rd_req;
    logic [2:0]       rd_lane;
    logic             rd_ack;
    logic             rd_valid;
    logic [CNT_W-1:0] rd_data;
    logic             rd_busy;
    logic [7:0]       err_flags;
    logic             clr_err;

    modport master (
        output lane_in, sel, rd_req, rd_lane, rd_ack, clr_err,
        input  rd_valid, rd_data, rd_busy, err_flags
    );

    modport slave (
        input  lane_in, sel, rd_req, rd_lane, rd_ack, clr_err,
        output rd_valid, rd_data, rd_busy, err_flags
    );
endinterface

// File: rtl/demux_lane_monitor.sv
// Per-lane rising-edge counters for the 1-to-8 demux outputs, with off-select
// activity flags and a read-and-clear host handshake.
module demux_lane_monitor #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    demux_lane_monitor_if.slave  bus
);
    localparam int GUARD_W = $clog2(SYNC_STAGES + 2);
    localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    logic [7:0]         sync_r [SYNC_STAGES];
    logic [7:0]         hist_r;
    logic [7:0]         rise_s;
    logic [CNT_W-1:0]   cnt_r [8];
    logic [2:0]         sel_q_r;
    logic [GUARD_W-1:0] guard_r;
    logic [7:0]         set_s;
    logic [7:0]         err_r;
    state_t             state_r;
    state_t             state_nxt_s;
    logic               capture_s;
    logic               rd_valid_r;
    logic               rd_busy_r;
    logic [CNT_W-1:0]   rd_data_r;

    // Lane input synchronizer chain plus the history flop used for edge detect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= 8'd0;
            end
            hist_r <= 8'd0;
        end else begin
            sync_r[0] <= bus.lane_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            hist_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign rise_s = sync_r[SYNC_STAGES-1] & ~hist_r;

    // Select history and the guard window that hides synchronizer lag after a select change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q_r <= 3'd0;
            guard_r <= {GUARD_W{1'b0}};
        end else begin
            sel_q_r <= bus.sel;
            if (bus.sel != sel_q_r) begin
                guard_r <= GUARD_LOAD;
            end else if (guard_r != {GUARD_W{1'b0}}) begin
                guard_r <= guard_r - {{(GUARD_W-1){1'b0}}, 1'b1};
            end else begin
                guard_r <= guard_r;
            end
        end
    end

    // Off-select edges outside the guard window raise an error.
    always_comb begin
        set_s = 8'd0;
        if (guard_r == {GUARD_W{1'b0}}) begin
            set_s = rise_s & ~(8'd1 << sel_q_r);
        end else begin
            set_s = 8'd0;
        end
    end

    // Sticky error flags; a same-cycle set beats the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_r <= 8'd0;
        end else begin
            err_r <= (bus.clr_err ? 8'd0 : err_r) | set_s;
        end
    end

    // Read FSM next-state and capture strobe.
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.rd_req) begin
                    state_nxt_s = ST_HOLD;
                    capture_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (bus.rd_ack) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Read FSM state and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            rd_valid_r <= 1'b0;
            rd_busy_r  <= 1'b0;
            rd_data_r  <= CNT_ZERO;
        end else begin
            state_r    <= state_nxt_s;
            rd_valid_r <= (state_nxt_s == ST_HOLD);
            rd_busy_r  <= (state_nxt_s == ST_HOLD);
            if (capture_s) begin
                rd_data_r <= cnt_r[bus.rd_lane];
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

    // Saturating edge counters; a capture clears the lane but keeps a colliding edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < 8; n++) begin
                cnt_r[n] <= CNT_ZERO;
            end
        end else begin
            for (int n = 0; n < 8; n++) begin
                if (capture_s && (bus.rd_lane == 3'(n))) begin
                    cnt_r[n] <= rise_s[n] ? CNT_ONE : CNT_ZERO;
                end else if (rise_s[n] && (cnt_r[n] != CNT_MAX)) begin
                    cnt_r[n] <= cnt_r[n] + CNT_ONE;
                end else begin
                    cnt_r[n] <= cnt_r[n];
                end
            end
        end
    end

    assign bus.rd_valid  = rd_valid_r;
    assign bus.rd_busy   = rd_busy_r;
    assign bus.rd_data   = rd_data_r;
    assign bus.err_flags = err_r;

endmodule

// File: tb/tb_demux_lane_monitor.sv
// Scoreboard bench for demux_lane_monitor: directed scenarios followed by
// random traffic, all checked against a cycle-level reference model.
module tb_demux_lane_monitor;
    localparam int CNT_W = 4;
    localparam int SYNC  = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk;
    logic reset;

    demux_lane_monitor_if #(.CNT_W(CNT_W)) bus ();

    demux_lane_monitor #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int         cnt_m [8];
    logic [7:0] hist_m [SYNC+1];
    logic [7:0] err_m       = 8'd0;
    logic [2:0] sel_prev_m  = 3'd0;
    int         last_change = -1000;
    int         edge_n      = 0;
    bit         hold_m      = 1'b0;
    int         exp_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a lane value seen at edge j produces a counted edge SYNC cycles later.
    initial begin
        logic [7:0] rise;
        bit         guard_ok;
        bit         cap;
        for (int n = 0; n < 8; n++) cnt_m[n] = 0;
        for (int j = 0; j <= SYNC; j++) hist_m[j] = 8'd0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                for (int n = 0; n < 8; n++) cnt_m[n] = 0;
                for (int j = 0; j <= SYNC; j++) hist_m[j] = 8'd0;
                err_m = 8'd0;
                sel_prev_m = 3'd0;
                last_change = -1000;
                hold_m = 1'b0;
                exp_q.delete();
            end else begin
                edge_n++;
                rise = hist_m[SYNC-1] & ~hist_m[SYNC];
                guard_ok = (edge_n - last_change) >= (SYNC + 2);
                err_m = (bus.clr_err ? 8'd0 : err_m) |
                        (guard_ok ? (rise & ~(8'd1 << sel_prev_m)) : 8'd0);
                cap = !hold_m && bus.rd_req;
                for (int n = 0; n < 8; n++) begin
                    if (cap && bus.rd_lane == 3'(n)) begin
                        exp_q.push_back(cnt_m[n]);
                        cnt_m[n] = rise[n] ? 1 : 0;
                    end else if (rise[n]) begin
                        cnt_m[n] = (cnt_m[n] < CMAX) ? cnt_m[n] + 1 : CMAX;
                    end
                end
                if (cap) hold_m = 1'b1;
                else if (hold_m && bus.rd_ack) hold_m = 1'b0;
                if (bus.sel != sel_prev_m) last_change = edge_n;
                sel_prev_m = bus.sel;
                for (int j = SYNC; j > 0; j--) hist_m[j] = hist_m[j-1];
                hist_m[0] = bus.lane_in;
            end
        end
    end

    // Monitor: pops the scoreboard when a read is presented and tracks status outputs.
    initial begin
        bit prev_valid = 1'b0;
        int held = 0;
        forever begin
            @(negedge clk);
            check("rd_valid", int'(bus.rd_valid), int'(hold_m));
            check("rd_busy", int'(bus.rd_busy), int'(hold_m));
            check("err_flags", int'(bus.err_flags), int'(err_m));
            if (bus.rd_valid && !prev_valid) begin
                check("sb_has_entry", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    held = exp_q.pop_front();
                    check("rd_data", int'(bus.rd_data), held);
                end
            end else if (bus.rd_valid) begin
                check("rd_data_stable", int'(bus.rd_data), held);
            end
            prev_valid = bus.rd_valid;
        end
    end

    task automatic pulse(input int l, input int hi, input int lo);
        @(negedge clk);
        bus.lane_in[l] = 1'b1;
        repeat (hi) @(negedge clk);
        bus.lane_in[l] = 1'b0;
        repeat (lo - 1) @(negedge clk);
    endtask

    task automatic do_read(input logic [2:0] lane, input int expv, input bit chk);
        @(negedge clk);
        bus.rd_req  = 1'b1;
        bus.rd_lane = lane;
        @(negedge clk);
        bus.rd_req = 1'b0;
        check("read_latency_valid", int'(bus.rd_valid), 1);
        if (chk) check("read_value", int'(bus.rd_data), expv);
        bus.rd_ack = 1'b1;
        @(negedge clk);
        bus.rd_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        bus.lane_in = 8'd0;
        bus.sel     = 3'd0;
        bus.rd_req  = 1'b0;
        bus.rd_lane = 3'd0;
        bus.rd_ack  = 1'b0;
        bus.clr_err = 1'b0;

        // Reset state
        #1 reset = 1'b1;
        #5;
        check("reset_rd_valid", int'(bus.rd_valid), 0);
        check("reset_rd_busy", int'(bus.rd_busy), 0);
        check("reset_rd_data", int'(bus.rd_data), 0);
        check("reset_err", int'(bus.err_flags), 0);
        #5 reset = 1'b0;
        for (int l = 0; l < 8; l++) do_read(3'(l), 0, 1'b1);

        // Basic count on the selected lane
        @(negedge clk) bus.sel = 3'd3;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 5; i++) pulse(3, 4, 4);
        repeat (6) @(negedge clk);
        do_read(3'd3, 5, 1'b1);
        do_read(3'd3, 0, 1'b1);
        check("basic_err", int'(bus.err_flags), 8'h00);

        // Saturation at 2^CNT_W-1 and restart after read
        @(negedge clk) bus.sel = 3'd0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 20; i++) pulse(0, 2, 2);
        repeat (6) @(negedge clk);
        do_read(3'd0, CMAX, 1'b1);
        do_read(3'd0, 0, 1'b1);

        // Guard window hides the old lane's trailing edge
        @(negedge clk) bus.sel = 3'd2;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 3; i++) pulse(2, 2, 2);
        @(negedge clk);
        bus.lane_in[2] = 1'b1;
        bus.sel = 3'd5;
        repeat (3) @(negedge clk);
        bus.lane_in[2] = 1'b0;
        repeat (8) @(negedge clk);
        check("guard_err", int'(bus.err_flags), 8'h00);
        pulse(6, 3, 3);
        repeat (4) @(negedge clk);
        check("off_sel_err", int'(bus.err_flags), 8'h40);
        @(negedge clk) bus.clr_err = 1'b1;
        @(negedge clk) bus.clr_err = 1'b0;
        check("clr_err", int'(bus.err_flags), 8'h00);
        @(negedge clk) bus.lane_in[6] = 1'b1;
        @(negedge clk);
        @(negedge clk) bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        bus.lane_in[6] = 1'b0;
        repeat (2) @(negedge clk);
        check("set_beats_clr", int'(bus.err_flags), 8'h40);
        @(negedge clk) bus.clr_err = 1'b1;
        @(negedge clk) bus.clr_err = 1'b0;

        // Capture in the same cycle as a counted edge
        @(negedge clk) bus.sel = 3'd1;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 7; i++) pulse(1, 2, 2);
        repeat (6) @(negedge clk);
        @(negedge clk) bus.lane_in[1] = 1'b1;
        @(negedge clk);
        do_read(3'd1, 7, 1'b1);
        @(negedge clk) bus.lane_in[1] = 1'b0;
        repeat (4) @(negedge clk);
        do_read(3'd1, 1, 1'b1);

        // Handshake corner cases
        for (int i = 0; i < 3; i++) pulse(4, 2, 2);
        repeat (6) @(negedge clk);
        @(negedge clk);
        bus.rd_req = 1'b1;
        bus.rd_lane = 3'd4;
        @(negedge clk) bus.rd_req = 1'b0;
        check("hold_data", int'(bus.rd_data), 3);
        @(negedge clk);
        bus.rd_req = 1'b1;
        bus.rd_lane = 3'd3;
        @(negedge clk) bus.rd_req = 1'b0;
        repeat (2) @(negedge clk);
        check("req_in_hold_data", int'(bus.rd_data), 3);
        check("req_in_hold_valid", int'(bus.rd_valid), 1);
        bus.rd_ack = 1'b1;
        @(negedge clk) bus.rd_ack = 1'b0;
        check("ack_busy", int'(bus.rd_busy), 0);
        bus.rd_ack = 1'b1;
        @(negedge clk) bus.rd_ack = 1'b0;
        check("ack_idle_busy", int'(bus.rd_busy), 0);
        check("ack_idle_valid", int'(bus.rd_valid), 0);
        @(negedge clk);
        bus.rd_req = 1'b1;
        bus.rd_lane = 3'd4;
        @(negedge clk) bus.rd_req = 1'b0;
        check("pre_reset_valid", int'(bus.rd_valid), 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("reset_in_hold_valid", int'(bus.rd_valid), 0);
        check("reset_in_hold_busy", int'(bus.rd_busy), 0);
        @(negedge clk) reset = 1'b0;

        // Random traffic
        repeat (3000) begin
            @(negedge clk);
            bus.lane_in = bus.lane_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 15) == 0) bus.sel = 3'($urandom_range(0, 7));
            bus.clr_err = ($urandom_range(0, 31) == 0);
            bus.rd_req  = ($urandom_range(0, 3) == 0);
            bus.rd_lane = 3'($urandom_range(0, 7));
            bus.rd_ack  = ($urandom_range(0, 2) == 0);
        end
        @(negedge clk);
        bus.rd_req  = 1'b0;
        bus.clr_err = 1'b0;
        bus.rd_ack  = 1'b1;
        repeat (2) @(negedge clk);
        bus.rd_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("scoreboard_drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
